// File: rtl/cmd_channel_arbiter_pkg.sv
// Shared definitions for the command-channel arbiter: FSM state encoding,
// default command width, common command codes and a counter sizing helper.
package cmd_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_ACK  = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } arbState_t;

   localparam int DEFAULT_CMD_W = 3;

   // Command codes shared by every requester (init sequencer, data engine, ...)
   localparam logic [DEFAULT_CMD_W-1:0] CMD_INIT0 = 3'd0;
   localparam logic [DEFAULT_CMD_W-1:0] CMD_INIT1 = 3'd1;
   localparam logic [DEFAULT_CMD_W-1:0] CMD_INIT2 = 3'd2;
   localparam logic [DEFAULT_CMD_W-1:0] CMD_INIT3 = 3'd3;

   // Width needed to hold the larger of the gap load and the timeout limit
   function automatic int cntWidth(input int gapCycles, input int timeoutCycles);
      int biggest;
      biggest = (gapCycles > timeoutCycles) ? gapCycles : timeoutCycles;
      return (biggest < 1) ? 1 : $clog2(biggest + 1);
   endfunction

endpackage

// File: rtl/cmd_channel_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the command arbiter.
// The arbiter uses the slave view; whatever drives requests and models the
// engine uses the master view.
interface cmd_channel_arbiter_if
   import cmd_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int CMD_W = DEFAULT_CMD_W
);

   logic [NREQ-1:0]       req;
   logic [NREQ*CMD_W-1:0] cmd_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       err;
   logic [CMD_W-1:0]      command;
   logic                  start;
   logic                  ready_command;
   logic                  busy;

   modport slave (
      input  req, cmd_in, ready_command,
      output gnt, done, err, command, start, busy
   );

   modport master (
      output req, cmd_in, ready_command,
      input  gnt, done, err, command, start, busy
   );

endinterface

// File: rtl/cmd_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: starting at i_ptr and wrapping, returns
// the first requester whose request bit is set, as one-hot and as index.
module rr_pick
   import cmd_arb_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [NREQ-1:0] o_winner,
   output logic [IDXW-1:0] o_winnerIdx,
   output logic            o_valid
);

   // Scan all requesters in priority order beginning at the pointer
   always_comb begin
      int  idx;
      logic found;
      o_winner    = '0;
      o_winnerIdx = '0;
      found       = 1'b0;
      idx         = 0;
      for (int off = 0; off < NREQ; off++) begin
         idx = (int'(i_ptr) + off) % NREQ;
         if (!found && i_req[IDXW'(idx)]) begin
            found                  = 1'b1;
            o_winner[IDXW'(idx)]   = 1'b1;
            o_winnerIdx            = IDXW'(idx);
         end
      end
      o_valid = found;
   end

endmodule

// File: rtl/cmd_channel_arbiter.sv
// Shares one command engine between NREQ requesters. Round-robin grant,
// one command in flight, a guard gap after every command and a timeout on
// both handshake waits. Every output comes straight from a register.
module cmd_channel_arbiter
   import cmd_arb_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int CMD_W          = DEFAULT_CMD_W,
   parameter int GAP_CYCLES     = 100,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic                 clk,
   input logic                 rst,
   cmd_channel_arbiter_if.slave bus
);

   localparam int IDXW = $clog2(NREQ);
   localparam int CNTW = cntWidth(GAP_CYCLES, TIMEOUT_CYCLES);

   localparam logic [CNTW-1:0] GAP_LOAD  = CNTW'(GAP_CYCLES);
   localparam logic [CNTW-1:0] TMO_LIMIT = CNTW'(TIMEOUT_CYCLES);

   arbState_t        r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [NREQ-1:0]  r_done;
   logic [NREQ-1:0]  r_err;
   logic [CMD_W-1:0] r_command;
   logic             r_start;
   logic             r_busy;
   logic [CNTW-1:0]  r_gapCnt;
   logic [CNTW-1:0]  r_tmoCnt;
   logic [IDXW-1:0]  r_rrPtr;

   logic [NREQ-1:0]  w_winner;
   logic [IDXW-1:0]  w_winIdx;
   logic             w_valid;
   logic [CMD_W-1:0] w_selCmd;
   logic [IDXW-1:0]  w_nextPtr;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rrPick (
      .i_req       (bus.req),
      .i_ptr       (r_rrPtr),
      .o_winner    (w_winner),
      .o_winnerIdx (w_winIdx),
      .o_valid     (w_valid)
   );

   // Winner's command slice and the pointer value just past the winner
   always_comb begin
      w_selCmd  = bus.cmd_in[w_winIdx*CMD_W +: CMD_W];
      w_nextPtr = (int'(w_winIdx) == NREQ - 1) ? '0 : w_winIdx + 1'b1;
   end

   // Arbitration and handshake FSM; done/err are single-cycle pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_done    <= '0;
         r_err     <= '0;
         r_command <= '0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
         r_gapCnt  <= '0;
         r_tmoCnt  <= '0;
         r_rrPtr   <= '0;
      end else begin
         r_done <= '0;
         r_err  <= '0;
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_gnt     <= w_winner;
                  r_command <= w_selCmd;
                  r_rrPtr   <= w_nextPtr;
                  r_busy    <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_start  <= 1'b1;
               r_tmoCnt <= '0;
               r_state  <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (!bus.ready_command) begin
                  r_tmoCnt <= '0;
                  r_state  <= WAIT_DONE;
               end else if (r_tmoCnt == TMO_LIMIT) begin
                  r_start  <= 1'b0;
                  r_err    <= r_gnt;
                  r_gapCnt <= GAP_LOAD;
                  r_state  <= GAP;
               end else begin
                  r_tmoCnt <= r_tmoCnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (bus.ready_command) begin
                  r_start  <= 1'b0;
                  r_done   <= r_gnt;
                  r_gapCnt <= GAP_LOAD;
                  r_state  <= GAP;
               end else if (r_tmoCnt == TMO_LIMIT) begin
                  r_start  <= 1'b0;
                  r_err    <= r_gnt;
                  r_gapCnt <= GAP_LOAD;
                  r_state  <= GAP;
               end else begin
                  r_tmoCnt <= r_tmoCnt + 1'b1;
               end
            end
            GAP: begin
               if (r_gapCnt == '0) begin
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_gapCnt <= r_gapCnt - 1'b1;
               end
            end
            default: begin
               r_start <= 1'b0;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.done    = r_done;
   assign bus.err     = r_err;
   assign bus.command = r_command;
   assign bus.start   = r_start;
   assign bus.busy    = r_busy;

endmodule

// File: tb/tb_cmd_channel_arbiter.sv
// Bench for cmd_channel_arbiter. Main instance: 3 requesters, gap 3,
// timeout 20. Second instance: 2 requesters with a zero guard gap.
// The bench plays both the requesters and the command engine.
module tb_cmd_channel_arbiter;
   import cmd_arb_pkg::*;

   localparam int N  = 3;
   localparam int CW = 3;
   localparam int G  = 3;
   localparam int T  = 20;

   logic clk;
   logic rst;
   int   assertCount = 0;
   int   failCount   = 0;
   int   modelPtr    = 0;
   int   modelPtr2   = 0;

   cmd_channel_arbiter_if #(.NREQ(N), .CMD_W(CW)) bus1 ();
   cmd_channel_arbiter_if #(.NREQ(2), .CMD_W(CW)) bus2 ();

   cmd_channel_arbiter #(
      .NREQ(N), .CMD_W(CW), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
   ) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   cmd_channel_arbiter #(
      .NREQ(2), .CMD_W(CW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(T)
   ) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] mask, input logic [N*CW-1:0] cmds);
      bus1.req    = mask;
      bus1.cmd_in = cmds;
   endtask

   // Reference arbitration: first set bit at or after the pointer, wrapping
   function automatic int modelPick(input logic [N-1:0] mask, input int ptr);
      for (int off = 0; off < N; off++) begin
         if (mask[(ptr + off) % N]) return (ptr + off) % N;
      end
      return -1;
   endfunction

   // One full command on instance 1, called at a falling edge in IDLE.
   // The engine drops ready ackDly cycles after start is first seen and
   // raises it doneDly cycles after that; delays above T never happen.
   task automatic runCommand(input logic [N-1:0] mask, input logic [N*CW-1:0] cmds,
                             input int ackDly, input int doneDly);
      int               w;
      int               startLen;
      bit               isErr;
      logic [CW-1:0]    expCmd;
      logic [N-1:0]     expGnt;
      applyStimulus(mask, cmds);
      w        = modelPick(mask, modelPtr);
      modelPtr = (w + 1) % N;
      expCmd   = cmds[w*CW +: CW];
      expGnt   = N'(1) << w;
      if (ackDly > T) begin
         startLen = T + 1;
         isErr    = 1'b1;
      end else if (doneDly > T) begin
         startLen = ackDly + T + 2;
         isErr    = 1'b1;
      end else begin
         startLen = ackDly + doneDly + 2;
         isErr    = 1'b0;
      end
      @(negedge clk);
      checkOutput("gntIssue", bus1.gnt, expGnt);
      checkOutput("cmdIssue", bus1.command, expCmd);
      checkOutput("busyIssue", bus1.busy, 1);
      checkOutput("startIssue", bus1.start, 0);
      for (int k = 0; k < startLen; k++) begin
         @(negedge clk);
         checkOutput("startHigh", bus1.start, 1);
         checkOutput("cmdHeld", bus1.command, expCmd);
         checkOutput("gntHeld", bus1.gnt, expGnt);
         checkOutput("noPulse", {bus1.done, bus1.err}, 0);
         if (k == 0) applyStimulus(N'($urandom), (N*CW)'($urandom));
         if (ackDly <= T && k == ackDly) bus1.ready_command = 1'b0;
         if (ackDly <= T && doneDly <= T && k == ackDly + 1 + doneDly) bus1.ready_command = 1'b1;
      end
      @(negedge clk);
      bus1.ready_command = 1'b1;
      checkOutput("startLow", bus1.start, 0);
      checkOutput("donePulse", bus1.done, isErr ? '0 : expGnt);
      checkOutput("errPulse", bus1.err, isErr ? expGnt : '0);
      checkOutput("gntInGap", bus1.gnt, expGnt);
      for (int j = 1; j <= G; j++) begin
         @(negedge clk);
         checkOutput("gapQuiet", {bus1.done, bus1.err, bus1.start}, 0);
         checkOutput("gapGnt", bus1.gnt, expGnt);
         checkOutput("gapBusy", bus1.busy, 1);
      end
      @(negedge clk);
      checkOutput("gntRelease", bus1.gnt, 0);
      checkOutput("busyRelease", bus1.busy, 0);
   endtask

   // Directed and randomized sequence
   initial begin
      logic [N-1:0]    mask;
      logic [N*CW-1:0] cmds;
      int              ackDly;
      int              doneDly;
      int              w;
      rst                = 1'b1;
      bus1.req           = '0;
      bus1.cmd_in        = '0;
      bus1.ready_command = 1'b1;
      bus2.req           = '0;
      bus2.cmd_in        = '0;
      bus2.ready_command = 1'b1;
      #3;
      checkOutput("rstOutputs", {bus1.gnt, bus1.done, bus1.err, bus1.command, bus1.start, bus1.busy}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idleNoReq", {bus1.gnt, bus1.busy}, 0);

      $display("[TB] single request");
      runCommand(3'b001, {3'd0, 3'd0, 3'd2}, 2, 4);

      $display("[TB] contention, all requesters held");
      for (int i = 0; i < 4; i++) runCommand(3'b111, {3'd5, 3'd3, 3'd1}, 1, 2);

      $display("[TB] timeouts");
      runCommand(3'b001, {3'd0, 3'd0, 3'd6}, T + 5, 0);
      runCommand(3'b100, {3'd7, 3'd0, 3'd0}, 1, T + 3);
      runCommand(3'b010, {3'd0, 3'd4, 3'd0}, T, 0);

      $display("[TB] randomized commands");
      for (int i = 0; i < 25; i++) begin
         mask    = N'($urandom_range(1, 7));
         cmds    = (N*CW)'($urandom);
         ackDly  = ($urandom_range(0, 7) == 0) ? T + 1 : $urandom_range(0, 6);
         doneDly = ($urandom_range(0, 7) == 0) ? T + 1 : $urandom_range(0, 6);
         runCommand(mask, cmds, ackDly, doneDly);
         if (i % 8 == 3) begin
            applyStimulus('0, '0);
            @(negedge clk);
            @(negedge clk);
            checkOutput("idleStays", {bus1.gnt, bus1.busy, bus1.start}, 0);
         end
      end

      $display("[TB] async reset in WAIT_DONE");
      applyStimulus(3'b111, {3'd3, 3'd2, 3'd1});
      w        = modelPick(3'b111, modelPtr);
      modelPtr = (w + 1) % N;
      @(negedge clk);
      @(negedge clk);
      bus1.ready_command = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("preRstStart", bus1.start, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncRst", {bus1.gnt, bus1.command, bus1.start, bus1.busy}, 0);
      @(negedge clk);
      rst                = 1'b0;
      bus1.ready_command = 1'b1;
      modelPtr           = 0;
      modelPtr2          = 0;
      runCommand(3'b111, {3'd6, 3'd5, 3'd4}, 0, 0);
      runCommand(3'b010, {3'd0, 3'd2, 3'd0}, 3, 1);

      $display("[TB] zero guard gap instance");
      bus2.req    = 2'b11;
      bus2.cmd_in = {3'd3, 3'd1};
      for (int i = 0; i < 3; i++) begin
         w         = (modelPtr2 + 0) % 2;
         modelPtr2 = (w + 1) % 2;
         @(negedge clk);
         checkOutput("g0Gnt", bus2.gnt, 2'(1) << w);
         checkOutput("g0Cmd", bus2.command, (w == 0) ? 3'd1 : 3'd3);
         @(negedge clk);
         checkOutput("g0Start", bus2.start, 1);
         bus2.ready_command = 1'b0;
         @(negedge clk);
         bus2.ready_command = 1'b1;
         @(negedge clk);
         checkOutput("g0Done", bus2.done, 2'(1) << w);
         checkOutput("g0StartLow", bus2.start, 0);
         @(negedge clk);
         checkOutput("g0Idle", {bus2.gnt, bus2.busy}, 0);
      end
      bus2.req = '0;
      @(negedge clk);
      checkOutput("g0Quiet", {bus2.gnt, bus2.busy}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
